// File: rtl/sme_window_gen_if.sv
// ---------------------------------------------------------------------------
// sme_window_gen_if
// Bundles the byte-stream input and the window output of sme_window_gen.
//   s_axis_tdata/tkeep/tvalid/tlast : input beat (lane 0 = earliest byte)
//   s_axis_tready                   : input beat accepted when high with tvalid
//   m_win_data                      : DATA_BYTES windows, window k at [W*k +: W]
//   m_win_valid                     : per-window "ends on a valid byte" flags
//   m_pos                           : packet byte offset of lane 0 of the beat
//   m_last                          : beat carries end of packet
//   m_valid/m_ready                 : output handshake
// modport slave  : the window generator itself
// modport master : the environment feeding it and draining its output
// ---------------------------------------------------------------------------
interface sme_window_gen_if #(
    parameter int DATA_BYTES = 8,
    parameter int WIN_BYTES  = 8,
    parameter int POS_WIDTH  = 16
);
    logic [8*DATA_BYTES-1:0]           s_axis_tdata;
    logic [DATA_BYTES-1:0]             s_axis_tkeep;
    logic                              s_axis_tvalid;
    logic                              s_axis_tlast;
    logic                              s_axis_tready;
    logic [DATA_BYTES*8*WIN_BYTES-1:0] m_win_data;
    logic [DATA_BYTES-1:0]             m_win_valid;
    logic [POS_WIDTH-1:0]              m_pos;
    logic                              m_last;
    logic                              m_valid;
    logic                              m_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_ready,
        output s_axis_tready, m_win_data, m_win_valid, m_pos, m_last, m_valid
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_ready,
        input  s_axis_tready, m_win_data, m_win_valid, m_pos, m_last, m_valid
    );
endinterface

// File: rtl/sme_window_gen.sv
// ---------------------------------------------------------------------------
// sme_window_gen
// Turns a DATA_BYTES-per-cycle packet byte stream into one WIN_BYTES-long
// sliding window per byte lane, each window ending on that lane's byte, for
// the multiplicative hash units of the string-matching engine.
//   clk   : clock
//   rst_n : asynchronous active-low reset, synchronous release
//   bus   : sme_window_gen_if.slave (stream in, windows out, one-deep
//           registered valid/ready output stage)
// WIN_BYTES must lie in 2..DATA_BYTES+1 so the history register is non-empty
// and each window reaches back at most one beat.
// ---------------------------------------------------------------------------
module sme_window_gen #(
    parameter int DATA_BYTES = 8,
    parameter int WIN_BYTES  = 8,
    parameter int POS_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sme_window_gen_if.slave        bus
);
    localparam int HIST_BYTES = WIN_BYTES - 1;
    localparam int HIST_W     = 8 * HIST_BYTES;
    localparam int WIN_W      = 8 * WIN_BYTES;
    localparam int IN_W       = 8 * DATA_BYTES;
    localparam int EXT_W      = IN_W + HIST_W;

    logic [HIST_W-1:0]           hist_p0;
    logic [POS_WIDTH-1:0]        cnt_p0;
    logic [EXT_W-1:0]            ext_p0;
    logic [DATA_BYTES*WIN_W-1:0] win_next_p0;
    logic                        accept_p0;

    logic [DATA_BYTES*WIN_W-1:0] win_data_p1;
    logic [DATA_BYTES-1:0]       win_valid_p1;
    logic [POS_WIDTH-1:0]        pos_p1;
    logic                        last_p1;
    logic                        vld_p1;

    // ---- stage p0: window assembly from current beat plus history ----
    assign bus.s_axis_tready = !vld_p1 || bus.m_ready;
    assign accept_p0         = bus.s_axis_tvalid && bus.s_axis_tready;

    // History sits below the current beat, so the extended vector is the
    // packet stream in byte order; window k is simply WIN_BYTES bytes of it
    // starting at byte k, with the newest byte landing in the top bits.
    assign ext_p0 = {bus.s_axis_tdata, hist_p0};

    always_comb begin
        win_next_p0 = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            win_next_p0[k*WIN_W +: WIN_W] = ext_p0[8*k +: WIN_W];
        end
    end

    // ---- stage p1: registered output and stream state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p0      <= '0;
            cnt_p0       <= '0;
            win_data_p1  <= '0;
            win_valid_p1 <= '0;
            pos_p1       <= '0;
            last_p1      <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            if (accept_p0) begin
                vld_p1       <= 1'b1;
                win_data_p1  <= win_next_p0;
                win_valid_p1 <= bus.s_axis_tkeep;
                pos_p1       <= cnt_p0;
                last_p1      <= bus.s_axis_tlast;
                // A last beat leaves the state exactly as a packet start
                // needs it: zero history, offset zero.
                if (bus.s_axis_tlast) begin
                    hist_p0 <= '0;
                    cnt_p0  <= '0;
                end else begin
                    hist_p0 <= bus.s_axis_tdata[IN_W-1 -: HIST_W];
                    cnt_p0  <= cnt_p0 + POS_WIDTH'(DATA_BYTES);
                end
            end else if (bus.m_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.m_win_data  = win_data_p1;
    assign bus.m_win_valid = win_valid_p1;
    assign bus.m_pos       = pos_p1;
    assign bus.m_last      = last_p1;
    assign bus.m_valid     = vld_p1;
endmodule

// File: tb/tb_sme_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sme_window_gen
// Drives packets into sme_window_gen, predicts every output beat from a
// byte-level packet model and compares them in a separate monitor process.
// ---------------------------------------------------------------------------
module tb_sme_window_gen;
    localparam int DB = 8;
    localparam int WB = 8;
    localparam int PW = 16;

    typedef struct {
        logic [DB*8*WB-1:0] win;
        logic [DB-1:0]      wv;
        logic [PW-1:0]      pos;
        logic               last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sme_window_gen_if #(.DATA_BYTES(DB), .WIN_BYTES(WB), .POS_WIDTH(PW)) bus ();

    sme_window_gen #(.DATA_BYTES(DB), .WIN_BYTES(WB), .POS_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    exp_t sb_q[$];
    logic [7:0] pkt_q[$];      // every byte of the current packet so far
    logic [PW-1:0] model_pos = '0;
    logic force_low = 1'b0;
    logic rdy_rand = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: window k ends at packet byte (beat start + k) and covers the
    // WB bytes before and including it; bytes before packet start read as 0.
    task automatic model_beat(input logic [63:0] d, input logic [7:0] keep,
                              input logic last, output exp_t e);
        int base;
        int idx;
        base = pkt_q.size();
        for (int b = 0; b < DB; b++) pkt_q.push_back(d[8*b +: 8]);
        e.win = '0;
        for (int k = 0; k < DB; k++) begin
            for (int b = 0; b < WB; b++) begin
                idx = base + k - (WB - 1) + b;
                e.win[64*k + 8*b +: 8] = (idx < 0) ? 8'h00 : pkt_q[idx];
            end
        end
        e.wv   = keep;
        e.pos  = model_pos;
        e.last = last;
        if (last) begin
            pkt_q.delete();
            model_pos = '0;
        end else begin
            model_pos = model_pos + PW'(DB);
        end
    endtask

    task automatic model_reset();
        pkt_q.delete();
        model_pos = '0;
        sb_q.delete();
    endtask

    // Present one beat, wait (bounded) for its acceptance, then predict it.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] keep, input logic last);
        logic acc;
        int n;
        exp_t e;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = keep;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end else begin
            model_beat(d, keep, last, e);
            sb_q.push_back(e);
        end
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.m_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 512'(sb_q.size()), 512'd0);
    endtask

    // Downstream ready: held low on request, otherwise steady or random.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = force_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compare each transferred beat, and hold steadiness while stalled.
    exp_t e_mon;
    exp_t held;
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_win", bus.m_win_data, held.win);
                chk("hold_pos", 512'(bus.m_pos), 512'(held.pos));
                chk("hold_wv_last", 512'({bus.m_win_valid, bus.m_last}), 512'({held.wv, held.last}));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=beat required=none pos=%0h", bus.m_pos);
                end else begin
                    e_mon = sb_q.pop_front();
                    chk("win_data", bus.m_win_data, e_mon.win);
                    chk("win_valid", 512'(bus.m_win_valid), 512'(e_mon.wv));
                    chk("pos", 512'(bus.m_pos), 512'(e_mon.pos));
                    chk("last", 512'(bus.m_last), 512'(e_mon.last));
                end
                stall_prev = 1'b0;
            end else if (bus.m_valid) begin
                stall_prev = 1'b1;
                held.win  = bus.m_win_data;
                held.wv   = bus.m_win_valid;
                held.pos  = bus.m_pos;
                held.last = bus.m_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        int nb;
        int nk;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b0;

        // Reset state
        #2;
        chk("rst_m_valid", 512'(bus.m_valid), 512'd0);
        chk("rst_win_data", bus.m_win_data, 512'd0);
        chk("rst_pos_wv_last", 512'({bus.m_pos, bus.m_win_valid, bus.m_last}), 512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_tready", 512'(bus.s_axis_tready), 512'd1);
        idle(2);

        // Directed two-beat packet
        send_beat(64'h0807060504030201, 8'hFF, 1'b0);
        @(negedge clk);
        chk("dir_b0_win7", 512'(bus.m_win_data[511:448]), 512'(64'h0807060504030201));
        chk("dir_b0_win0", 512'(bus.m_win_data[63:0]), 512'(64'h0100000000000000));
        chk("dir_b0_pos_wv", 512'({bus.m_pos, bus.m_win_valid}), 512'({16'd0, 8'hFF}));
        idle(1);
        send_beat(64'h100F0E0D0C0B0A09, 8'hFF, 1'b1);
        @(negedge clk);
        chk("dir_b1_win0", 512'(bus.m_win_data[63:0]), 512'(64'h0908070605040302));
        chk("dir_b1_pos_last", 512'({bus.m_pos, bus.m_last}), 512'({16'd8, 1'b1}));
        idle(1);
        send_beat({8{8'hAA}}, 8'hFF, 1'b0);
        @(negedge clk);
        chk("dir_aa_win0", 512'(bus.m_win_data[63:0]), 512'(64'hAA00000000000000));
        chk("dir_aa_pos", 512'(bus.m_pos), 512'd0);
        idle(1);

        // Partial last beat, then a fresh packet
        send_beat(64'h1122334455667788, 8'h07, 1'b1);
        @(negedge clk);
        chk("dir_partial_wv_last", 512'({bus.m_win_valid, bus.m_last}), 512'({8'h07, 1'b1}));
        idle(1);
        send_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1);
        @(negedge clk);
        chk("dir_next_pkt_pos", 512'(bus.m_pos), 512'd0);
        idle(1);
        drain();

        // Stall with continuous input: one accept, then tready low, no loss
        force_low = 1'b1;
        idle(1);
        fork
            begin
                for (int j = 0; j < 4; j++) send_beat({$urandom, $urandom}, 8'hFF, j == 3);
            end
            begin
                repeat (2) @(negedge clk);
                chk("hold_tready", 512'(bus.s_axis_tready), 512'd0);
                repeat (4) @(posedge clk);
                force_low = 1'b0;
            end
        join
        drain();

        // Randomised packets with random gaps and random backpressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                nk = $urandom_range(1, 8);
                send_beat({$urandom, $urandom},
                          (b == nb - 1) ? 8'((16'h1 << nk) - 16'h1) : 8'hFF,
                          b == nb - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rdy_rand = 1'b0;
        drain();

        // Long packet: position wraps, full throughput
        c0 = cyc_cnt;
        for (int b = 0; b < 8193; b++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        chk("throughput_cycles", 512'(cyc_cnt - c0), 512'd8193);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        drain();

        // Reset mid-packet with an output beat pending
        force_low = 1'b1;
        idle(1);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 512'(bus.m_valid), 512'd0);
        chk("midrst_pos_wv", 512'({bus.m_pos, bus.m_win_valid}), 512'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_low = 1'b0;
        idle(2);
        send_beat({8{8'h55}}, 8'hFF, 1'b0);
        @(negedge clk);
        chk("midrst_win0", 512'(bus.m_win_data[63:0]), 512'(64'h5500000000000000));
        chk("midrst_pos", 512'(bus.m_pos), 512'd0);
        idle(1);
        send_beat({$urandom, $urandom}, 8'h3F, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sme_window_gen.md
Name: sme_window_gen

Overview:
- Upstream feeder for the string-matching engine's multiplicative hash units.
- Converts an 8-byte/cycle packet byte stream into one 64-bit sliding window per byte lane, each ending at that lane's byte.
- Each window drives one hash instance directly.
- Outputs per-window validity, packet position and end-of-packet through a one-deep registered valid/ready stage.

Parameters:
- DATA_BYTES, 8, byte lanes per beat (and windows produced per beat).
- WIN_BYTES, 8, window length in bytes (window width = 8*WIN_BYTES = 64); must satisfy WIN_BYTES <= DATA_BYTES+1.
- POS_WIDTH, 16, width of packet byte-position counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  8*DATA_BYTES  input bytes; lane 0 (bits 7:0) is earliest in stream
- s_axis_tkeep  in  DATA_BYTES  byte-valid mask, contiguous from lane 0
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  input accepted when high with tvalid
- m_win_data  out  DATA_BYTES*8*WIN_BYTES  window k at bits [64k+63:64k]
- m_win_valid  out  DATA_BYTES  bit k set when window k ends on a valid byte
- m_pos  out  POS_WIDTH  packet byte offset of lane 0 of this beat
- m_last  out  1  beat carries end of packet
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_win_data=0, m_win_valid=0, m_pos=0, m_last=0, history=0, position counter=0. s_axis_tready=1 once reset is deasserted.
- Handshake:
  - s_axis_tready = !m_valid || m_ready (combinational).
  - Input accept = s_axis_tvalid && s_axis_tready.
  - m_valid is set on accept. It is cleared on m_ready without a new accept.
  - Output fields change only on accept. They are held stable while m_valid && !m_ready.
- Latency: 1 cycle from input accept to m_valid.
- Full throughput: one beat per cycle when m_ready stays high.
- Window construction:
  - Byte index i = lane k of the current beat.
  - Window k = bytes i-(WIN_BYTES-1)..i. Byte i goes in bits [63:56] of the window; byte i-7 goes in bits [7:0].
  - Bytes before i come from the current beat's lower lanes, then from the history register.
  - History = last WIN_BYTES-1 bytes of the previous accepted beat of the same packet.
- Packet start: history is all-zero. Windows extending before byte 0 of the packet are zero-filled in the missing bytes and are still valid.
- m_win_valid[k] = s_axis_tkeep[k] of the accepted beat. Lanes with tkeep=0 yield window data computed from the raw tdata, with their valid bit low.
- History update on accept:
  - non-last beat: history <= upper WIN_BYTES-1 bytes of tdata.
  - last beat: history <= 0 and position counter <= 0.
- Position:
  - m_pos = counter value at accept.
  - Counter += DATA_BYTES on each non-last accept.
  - Counter wraps modulo 2^POS_WIDTH silently.
- m_last = s_axis_tlast of the accepted beat.
- Single-beat packets (tvalid with tlast on the first beat) are legal.
- Non-contiguous or partial tkeep on a non-last beat is a protocol violation. Output is undefined but the block must not lock up.
- Reset asserted mid-packet: all state is cleared immediately and any in-flight output beat is dropped. The next accepted beat is treated as a packet start.

Test Plan:
- Two-beat packet, beat0 bytes 0x01..0x08 (lane0=0x01), tkeep=0xFF -> window7=64'h0807060504030201, window0=64'h0100000000000000, m_pos=0, m_win_valid=0xFF. Beat1 bytes 0x09..0x10 with tlast -> window0=64'h0908070605040302, m_pos=8, m_last=1.
- After that packet, a new beat of 0xAA bytes -> window0=64'hAA00000000000000 (history cleared) and m_pos=0.
- Last beat with tkeep=0x07 -> m_win_valid=0x07, m_last=1. The following packet starts at m_pos=0.
- Hold m_ready=0 for 5 cycles with tvalid=1 -> s_axis_tready=0 after the first accept, outputs stable, no beat lost or duplicated. Release -> beats emerge in order at 1/cycle.
- Stream 8193 non-last beats -> m_pos wraps 0xFFF8 -> 0x0000 at beat 8192.
- Assert rst_n=0 mid-packet with m_valid=1 -> m_valid=0 the same cycle. After release, first beat output shows zero history and m_pos=0.
